// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Size codes, lane codes, FSM state and latched transaction bundle.
package dm_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] LANE_B0  = 4'h1;
  localparam logic [3:0] LANE_B1  = 4'h2;
  localparam logic [3:0] LANE_B2  = 4'h4;
  localparam logic [3:0] LANE_B3  = 4'h8;
  localparam logic [3:0] LANE_HLO = 4'h3;
  localparam logic [3:0] LANE_HHI = 4'h9;
  localparam logic [3:0] LANE_W   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        port;
  } txn_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Lane code, alignment check and load extraction for one access.
// Purely combinational; size 3 behaves as a word.
module dm_lane_unit
  import dm_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sign,
  input  logic [31:0] rdata,
  output logic [3:0]  lane,
  output logic        aligned,
  output logic [31:0] ldata
);

  logic        is_b;
  logic        is_h;
  logic [31:0] bsh;
  logic [31:0] hsh;

  assign is_b = (size == SZ_BYTE);
  assign is_h = (size == SZ_HALF);
  assign bsh  = rdata >> {lo, 3'b000};
  assign hsh  = rdata >> {lo[1], 4'b0000};

  always_comb begin
    lane    = LANE_W;
    aligned = 1'b1;
    ldata   = rdata;
    unique case (1'b1)
      is_b: begin
        unique case (lo)
          2'd0:    lane = LANE_B0;
          2'd1:    lane = LANE_B1;
          2'd2:    lane = LANE_B2;
          default: lane = LANE_B3;
        endcase
        ldata = {{24{sign & bsh[7]}}, bsh[7:0]};
      end
      is_h: begin
        lane    = lo[1] ? LANE_HHI : LANE_HLO;
        aligned = ~lo[0];
        ldata   = {{16{sign & hsh[15]}}, hsh[15:0]};
      end
      default: begin
        lane    = LANE_W;
        aligned = (lo == 2'd0);
        ldata   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter from two load/store ports to one data memory.
// One transaction in flight; registered, lane-extended response.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [1:0]    req0_size,
  input  logic          req0_sign,
  input  logic [31:0]   req0_addr,
  input  logic [31:0]   req0_wdata,
  input  logic [31:0]   req0_pc,
  output logic          rsp0_valid,
  output logic [31:0]   rsp0_rdata,
  output logic          rsp0_err,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [1:0]    req1_size,
  input  logic          req1_sign,
  input  logic [31:0]   req1_addr,
  input  logic [31:0]   req1_wdata,
  input  logic [31:0]   req1_pc,
  output logic          rsp1_valid,
  output logic [31:0]   rsp1_rdata,
  output logic          rsp1_err,
  output logic          mem_we,
  output logic [3:0]    mem_store_sig,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wdata,
  output logic [31:0]   mem_pc,
  output logic [31:0]   mem_addr,
  input  logic [31:0]   mem_rdata
);

  state_e      state_q, state_d;
  txn_t        txn_q, txn_d;
  logic        last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        can_acc;
  logic        gnt;
  logic        hs;
  logic        aligned;
  logic [3:0]  lane;
  logic [31:0] ldata;

  dm_lane_unit u_lane (
    .size    (txn_q.size),
    .lo      (txn_q.addr[1:0]),
    .sign    (txn_q.sign),
    .rdata   (mem_rdata),
    .lane    (lane),
    .aligned (aligned),
    .ldata   (ldata)
  );

  // Tie goes to the port that did not win last time.
  assign can_acc = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign gnt     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = can_acc & req0_valid & ~gnt;
  assign req1_ready = can_acc & req1_valid & gnt;
  assign hs      = req0_ready | req1_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = hs ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = hs ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    txn_d   = txn_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (hs) begin
      last_d = gnt;
      if (gnt)
        txn_d = '{req1_we, req1_size, req1_sign, req1_addr,
                  req1_wdata, req1_pc, 1'b1};
      else
        txn_d = '{req0_we, req0_size, req0_sign, req0_addr,
                  req0_wdata, req0_pc, 1'b0};
    end
    if (state_q == ST_ACCESS) begin
      rdata_d = (txn_q.we | ~aligned) ? 32'd0 : ldata;
      err_d   = ~aligned;
    end
  end

  always_comb begin
    mem_we        = (state_q == ST_ACCESS) & txn_q.we & aligned & reset;
    mem_store_sig = lane;
    mem_a         = txn_q.addr[AW+1:2];
    mem_wdata     = txn_q.wdata;
    mem_pc        = txn_q.pc;
    mem_addr      = txn_q.addr;
    rsp0_valid    = (state_q == ST_RESP) & ~txn_q.port;
    rsp1_valid    = (state_q == ST_RESP) & txn_q.port;
    rsp0_rdata    = rsp0_valid ? rdata_q : 32'd0;
    rsp1_rdata    = rsp1_valid ? rdata_q : 32'd0;
    rsp0_err      = rsp0_valid & err_q;
    rsp1_err      = rsp1_valid & err_q;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a lane-decoding memory.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, req0_sign;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata, req0_pc;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_sign;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata, req1_pc;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_we;
  logic [3:0]  mem_store_sig;
  logic [9:0]  mem_a;
  logic [31:0] mem_wdata, mem_pc, mem_addr, mem_rdata;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(10)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_size(req0_size),
    .req0_sign(req0_sign), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_pc(req0_pc),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_size(req1_size),
    .req1_sign(req1_sign), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_pc(req1_pc),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_store_sig(mem_store_sig),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_a];

  // Memory decodes the lane code itself; wdata arrives right-aligned.
  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_store_sig)
        4'h1: mem[mem_a][7:0]   <= mem_wdata[7:0];
        4'h2: mem[mem_a][15:8]  <= mem_wdata[7:0];
        4'h4: mem[mem_a][23:16] <= mem_wdata[7:0];
        4'h8: mem[mem_a][31:24] <= mem_wdata[7:0];
        4'h3: mem[mem_a][15:0]  <= mem_wdata[15:0];
        4'h9: mem[mem_a][31:16] <= mem_wdata[15:0];
        4'hF: mem[mem_a]        <= mem_wdata;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz;
      req0_sign = sg; req0_addr = a; req0_wdata = wd;
      req0_pc = 32'h1000 + a;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz;
      req1_sign = sg; req1_addr = a; req1_wdata = wd;
      req1_pc = 32'h2000 + a;
    end
  endtask

  // One lone transaction: accept, ACCESS, RESP checks.
  task automatic txn(input string tag, input int p, input logic we,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] esig, input logic ewe,
                     input logic [31:0] erd, input logic eerr);
    set_req(p, 1'b1, we, sz, sg, a, wd);
    #1;
    chk({tag, ".rdy"}, {31'd0, p == 0 ? req0_ready : req1_ready}, 1);
    @(negedge clk);
    set_req(p, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    #1;
    chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, ewe});
    chk({tag, ".a"}, {22'd0, mem_a}, {22'd0, a[11:2]});
    chk({tag, ".sig"}, {28'd0, mem_store_sig}, {28'd0, esig});
    chk({tag, ".maddr"}, mem_addr, a);
    @(negedge clk);
    #1;
    chk({tag, ".vld"}, {30'd0, rsp1_valid, rsp0_valid},
        p == 0 ? 32'd1 : 32'd2);
    chk({tag, ".rd"}, p == 0 ? rsp0_rdata : rsp1_rdata, erd);
    chk({tag, ".err"}, {31'd0, p == 0 ? rsp0_err : rsp1_err},
        {31'd0, eerr});
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[1] = 32'hA5A5A5A5;
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.vld", {30'd0, rsp1_valid, rsp0_valid}, 0);
    chk("rst.err", {30'd0, rsp1_err, rsp0_err}, 0);
    chk("rst.rd0", rsp0_rdata, 0);
    chk("rst.rd1", rsp1_rdata, 0);
    chk("rst.we", {31'd0, mem_we}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    txn("sw8", 0, 1, 2'd2, 0, 32'h8, 32'h12345678,
        4'hF, 1, 32'h0, 0);
    chk("sw8.mem", mem[2], 32'h12345678);
    txn("lbu9", 0, 0, 2'd0, 0, 32'h9, 32'h0,
        4'h2, 0, 32'h00000056, 0);
    txn("shE", 1, 1, 2'd1, 0, 32'hE, 32'h00008001,
        4'h9, 1, 32'h0, 0);
    chk("shE.mem", mem[3], 32'h80010000);
    txn("lhE", 0, 0, 2'd1, 1, 32'hE, 32'h0,
        4'h9, 0, 32'hFFFF8001, 0);
    txn("lhuE", 1, 0, 2'd1, 0, 32'hE, 32'h0,
        4'h9, 0, 32'h00008001, 0);
    txn("lbF", 0, 0, 2'd0, 1, 32'hF, 32'h0,
        4'h8, 0, 32'hFFFFFF80, 0);
    txn("lh8", 0, 0, 2'd1, 1, 32'h8, 32'h0,
        4'h3, 0, 32'h00005678, 0);
    txn("sw6", 0, 1, 2'd2, 0, 32'h6, 32'hDEADBEEF,
        4'hF, 0, 32'h0, 1);
    chk("sw6.mem", mem[1], 32'hA5A5A5A5);
    txn("lh3", 1, 0, 2'd1, 1, 32'h3, 32'h0,
        4'h9, 0, 32'h0, 1);
    txn("lwrap", 0, 0, 2'd3, 0, 32'h1008, 32'h0,
        4'hF, 0, 32'h12345678, 0);

    // Contention from a fresh reset: grants alternate 0,1,0,1.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d.rdy", i), {30'd0, req1_ready, req0_ready},
          (i % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d.busy", i),
          {30'd0, req1_ready, req0_ready}, 0);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d.vld", i), {30'd0, rsp1_valid, rsp0_valid},
          (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d.rd", i),
          (i % 2 == 0) ? rsp0_rdata : rsp1_rdata,
          (i % 2 == 0) ? 32'h12345678 : 32'h80010000);
    end
    set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;

    // Reset asserted during the ACCESS cycle of a store.
    set_req(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h55555555);
    #1;
    chk("rmo.rdy", {31'd0, req1_ready}, 1);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    chk("rmo.we", {31'd0, mem_we}, 0);
    @(negedge clk);
    #1;
    chk("rmo.vld", {30'd0, rsp1_valid, rsp0_valid}, 0);
    chk("rmo.mem", mem[4], 32'd0);
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0);
    #1;
    chk("rmo.tie", {30'd0, req1_ready, req0_ready}, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("rmo.rsp", {30'd0, rsp1_valid, rsp0_valid}, 1);
    chk("rmo.rd", rsp0_rdata, 32'h12345678);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Sits between two load/store requesters and the single-port data memory: port 0 is the CPU MEM stage, port 1 is the debug/DMA loader.
- Arbitrates between the two ports round-robin, with one transaction in flight at a time.
- Translates byte address and access size into the memory's word index and store-lane code.
- Returns lane-extracted, sign- or zero-extended load data through a registered response.

Parameters:
- AW, 10, word-index width driven to memory (memory depth 2^AW words).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- reqN_valid  in  1  request present (N = 0, 1; all reqN_/rspN_ ports duplicated per port)
- reqN_ready  out  1  request accepted this cycle
- reqN_we  in  1  1 = store, 0 = load
- reqN_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
- reqN_sign  in  1  load sign-extend enable
- reqN_addr  in  32  byte address
- reqN_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- reqN_pc  in  32  PC tag, passed to memory for trace
- rspN_valid  out  1  one-cycle response strobe
- rspN_rdata  out  32  extended load data (0 for stores and errors)
- rspN_err  out  1  misaligned access flag, valid with rspN_valid
- mem_we  out  1  memory write enable
- mem_store_sig  out  4  lane code
- mem_a  out  AW  word index = addr[AW+1:2]
- mem_wdata  out  32  latched reqN_wdata, unmodified
- mem_pc  out  32  latched PC tag
- mem_addr  out  32  latched byte address
- mem_rdata  in  32  combinational read word

Behaviour:
- Reset (reset low at a posedge):
  - state = IDLE, last_grant = 1, all rsp*_valid/err = 0, rsp*_rdata = 0.
  - mem_we is forced 0 combinationally whenever reset is low, so no write occurs on a reset edge even mid-ACCESS.
- FSM states: IDLE, ACCESS, RESP.
- Accept:
  - In IDLE or RESP, the granted port's reqN_ready = 1 when its valid is high. Handshake = valid & ready.
  - At most one ready is high per cycle.
  - On handshake, latch we/size/sign/addr/wdata/pc and port id. Next state = ACCESS.
- Arbitration:
  - One valid: grant it.
  - Both valid: grant the port != last_grant.
  - last_grant updates on each handshake.
- ACCESS (exactly 1 cycle):
  - Drive mem_a/mem_wdata/mem_pc/mem_addr from latches.
  - mem_we = latched we & aligned & reset.
  - At the clock edge, register the extracted load data. Next state = RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle on the latched port only.
  - May accept a new request in the same cycle (back-to-back: one transaction per 2 cycles). Otherwise go to IDLE.
- Lane code (mem_store_sig) by size and addr[1:0]:
  - byte: 0→4'h1, 1→4'h2, 2→4'h4, 3→4'h8.
  - half: 0→4'h3, 2→4'h9.
  - word: 4'hF.
- Alignment:
  - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned access: no write, rdata = 0, rsp_err = 1.
- Load extract:
  - byte = mem_rdata[8*addr[1:0]+7 -: 8]; half = mem_rdata[16*addr[1]+15 -: 16].
  - Sign-extend if sign, else zero-extend. Word passes through.
- Store response: rdata = 0, err per alignment.
- Valid held low mid-ACCESS: no effect. A request not granted must hold valid; ready does not depend on the latched port.
- Address bits above AW+1 are ignored (wrap-around modulo memory size).

Decomposition:
- Package dm_arb_pkg holds:
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - lane-code constants LANE_B0..B3, LANE_HLO=4'h3, LANE_HHI=4'h9, LANE_W=4'hF;
  - FSM state enum.
- One natural sub-module: dm_lane_unit (combinational). It takes size, addr[1:0] and sign and returns the lane code, the aligned flag and the extracted load data.

Test Plan:
- Single store, port 0: word 0x12345678 to addr 0x8. Required: mem_we high one cycle, mem_a=2, store_sig=F. Then lbu addr 0x9 → rsp0_rdata=0x00000056, rsp0_valid 2 cycles after handshake.
- Sign extension, half: store half 0x8001 to 0xE (store_sig=9). Then lh 0xE → 0xFFFF8001; lhu 0xE → 0x00008001.
- Contention: both valid every cycle from reset. Required grants 0,1,0,1; each rspN_valid on its own port only; back-to-back spacing 2 cycles.
- Misalignment: sw to 0x6, then lh from 0x3. Required: mem_we stays 0, rsp_err=1, rdata=0, memory word 1 unchanged.
- Reset mid-op: drive reset low in the ACCESS cycle of a store. Required: no write, no rsp_valid; after release, port 0 wins the first tie.
